// File: rtl/exmem_pkg.sv
// Shared types and defaults for the mprjram Wishbone memory controller.
package exmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int         DELAY_DEF   = 10;
    localparam int         ADDR_W_DEF  = 10;
    localparam logic [7:0] BASE_HI_DEF = 8'h38;
    localparam int         WAIT_CNT_W  = 8;
    localparam int         STATS_W     = 32;

endpackage

// File: rtl/bram_sp32.sv
// Single-port 2^ADDR_W x 32 RAM with synchronous read and per-byte write enables.
module bram_sp32 #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q;

    // Read port only updates on reads, so the last read word is held across writes.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_i[b]) begin
                        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_exmem_ctrl.sv
// Wishbone slave for the mprjram window: DELAY wait states, then one BRAM access.
// Define STATS_EN to add read/write completion counters on stats_o.
module wb_exmem_ctrl
    import exmem_pkg::*;
#(
    parameter int         DELAY   = DELAY_DEF,
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter logic [7:0] BASE_HI = BASE_HI_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [63:0] stats_o
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(DELAY - 1);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [3:0]              sel_q, sel_d;
    logic [ADDR_W-1:0]       adr_q, adr_d;
    logic [31:0]             dat_q, dat_d;
    logic                    rdValid_q, rdValid_d;
    logic                    hit;
    logic                    bramEn;
    logic [31:0]             bramRdata;
    logic                    unusedAdr;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
    assign bramEn    = (state_q == WAIT) && wbs_cyc_i && (cnt_q == LAST_CNT);
    assign unusedAdr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdValid_d = rdValid_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    adr_d   = wbs_adr_i[ADDR_W+1:2];
                    dat_d   = wbs_dat_i;
                end
            end
            WAIT: begin
                // Dropping cyc abandons the request before any memory side effect.
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rdValid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + WAIT_CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdValid_q <= rdValid_d;
        end
    end

    bram_sp32 #(
        .ADDR_W (ADDR_W)
    ) uBram (
        .clk_i   (wb_clk_i),
        .en_i    (bramEn),
        .we_i    (we_q),
        .sel_i   (sel_q),
        .addr_i  (adr_q),
        .wdata_i (dat_q),
        .rdata_o (bramRdata)
    );

    assign wbs_ack_o = (state_q == ACK);
    assign wbs_dat_o = rdValid_q ? bramRdata : '0;

`ifdef STATS_EN
    logic [STATS_W-1:0] rdCnt_q, wrCnt_q;

    // Counted on the ack cycle, so aborted or reset requests never register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rdCnt_q <= '0;
            wrCnt_q <= '0;
        end else if (state_q == ACK) begin
            if (we_q) begin
                wrCnt_q <= wrCnt_q + STATS_W'(1);
            end else begin
                rdCnt_q <= rdCnt_q + STATS_W'(1);
            end
        end
    end

    assign stats_o = {wrCnt_q, rdCnt_q};
`else
    assign stats_o = '0;
`endif

endmodule

// File: tb/tb_wb_exmem_ctrl.sv
// Bench for wb_exmem_ctrl: transaction-level model with absolute edge numbers plus directed vectors.
// Honours STATS_EN the same way as the design.
module tb_wb_exmem_ctrl;

    localparam int DELAY  = 10;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [63:0] stats_o;

    int vectors     = 0;
    int miscompares = 0;

    int          edgeCnt    = 0;
    bit          modelReady = 0;
    bit          pending    = 0;
    int          doneEdge   = 0;
    int          busyUntil  = 0;
    bit          expAck     = 0;
    logic [31:0] expDat     = '0;
    logic        reqWe;
    logic [3:0]  reqSel;
    logic [31:0] reqAdr;
    logic [31:0] reqDat;
    logic [31:0] memModel [int];
    int          wrCntM = 0;
    int          rdCntM = 0;

    wb_exmem_ctrl #(
        .DELAY   (DELAY),
        .ADDR_W  (ADDR_W),
        .BASE_HI (8'h38)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .stats_o   (stats_o)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic modelReset();
        pending    = 0;
        expAck     = 0;
        expDat     = '0;
        busyUntil  = edgeCnt;
        wrCntM     = 0;
        rdCntM     = 0;
        modelReady = 1;
    endtask

    always @(posedge wb_rst_i) modelReset();

    // A request accepted at edge N completes at edge N+DELAY; the slave is deaf until N+DELAY+2.
    always @(posedge wb_clk_i) begin
        logic [31:0] m;
        logic [31:0] old;
        int          w;
        edgeCnt++;
        expAck = 0;
        if (wb_rst_i) begin
            modelReset();
        end else if (pending) begin
            if (!wbs_cyc_i) begin
                pending   = 0;
                busyUntil = edgeCnt;
            end else if (edgeCnt == doneEdge) begin
                pending   = 0;
                busyUntil = edgeCnt + 1;
                expAck    = 1;
                w         = wordOf(reqAdr);
                old       = memModel.exists(w) ? memModel[w] : 32'hx;
                if (reqWe) begin
                    m = {{8{reqSel[3]}}, {8{reqSel[2]}}, {8{reqSel[1]}}, {8{reqSel[0]}}};
                    memModel[w] = (old & ~m) | (reqDat & m);
                    wrCntM++;
                end else begin
                    expDat = old;
                    rdCntM++;
                end
            end
        end else if (edgeCnt > busyUntil && wbs_cyc_i && wbs_stb_i && wbs_adr_i[31:24] == 8'h38) begin
            pending  = 1;
            doneEdge = edgeCnt + DELAY;
            reqWe    = wbs_we_i;
            reqSel   = wbs_sel_i;
            reqAdr   = wbs_adr_i;
            reqDat   = wbs_dat_i;
        end
    end

    always @(negedge wb_clk_i) begin
        if (modelReady) begin
            checkOutput("ack", 64'(wbs_ack_o), 64'(expAck));
            if (!$isunknown(expDat)) begin
                checkOutput("datO", 64'(wbs_dat_o), 64'(expDat));
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                 input logic [31:0] dat);
        @(posedge wb_clk_i);
        #2;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
    endtask

    task automatic releaseBus();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wbXfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, output logic [31:0] rdat, output int lat);
        lat  = -1;
        rdat = 'x;
        applyStimulus(we, sel, adr, dat);
        for (int i = 0; i < 300; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                lat  = i;
                rdat = wbs_dat_o;
                break;
            end
        end
        @(posedge wb_clk_i);
        #2;
        releaseBus();
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ackTimeout: got no ack, want ack for adr 0x%h", adr);
        end
    endtask

    task automatic countAcks(input int cycles, output int acks);
        acks = 0;
        repeat (cycles) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
    endtask

    // Holds the request for 'edges' accepting/counting edges, then drops cyc.
    task automatic abortReq(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input int edges, output int acks);
        applyStimulus(we, 4'hF, adr, dat);
        repeat (edges) @(posedge wb_clk_i);
        #2;
        releaseBus();
        countAcks(20, acks);
    endtask

    task automatic pulseReset();
        @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          acks;
        logic [63:0] expStats;

        wb_rst_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        releaseBus();
        #1 wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        checkOutput("rstAck", 64'(wbs_ack_o), 64'h0);
        checkOutput("rstDat", 64'(wbs_dat_o), 64'h0);

        wbXfer(1'b1, 4'hF, 32'h3800_0000, 32'h0102_0304, rd, lat);
        wbXfer(1'b1, 4'hF, 32'h3800_0010, 32'h1122_3344, rd, lat);
        checkOutput("wrLatency", 64'(lat), 64'd11);
        wbXfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, rd, lat);
        checkOutput("rdLatency", 64'(lat), 64'd11);
        checkOutput("rdFull", 64'(rd), 64'h1122_3344);

        wbXfer(1'b1, 4'b0101, 32'h3800_0010, 32'hAABB_CCDD, rd, lat);
        wbXfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, rd, lat);
        checkOutput("rdPartial", 64'(rd), 64'h11BB_33DD);

        applyStimulus(1'b1, 4'hF, 32'h3000_0000, 32'hFFFF_FFFF);
        countAcks(50, acks);
        releaseBus();
        checkOutput("noAckLow", 64'(acks), 64'd0);
        applyStimulus(1'b1, 4'hF, 32'h3900_0010, 32'hFFFF_FFFF);
        countAcks(50, acks);
        releaseBus();
        checkOutput("noAckHigh", 64'(acks), 64'd0);
        wbXfer(1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        checkOutput("missKeep0", 64'(rd), 64'h0102_0304);
        wbXfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, rd, lat);
        checkOutput("missKeep10", 64'(rd), 64'h11BB_33DD);

        abortReq(1'b1, 32'h3800_0000, 32'hDEAD_BEEF, 6, acks);
        checkOutput("abortNoAck", 64'(acks), 64'd0);
        wbXfer(1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        checkOutput("abortKeep", 64'(rd), 64'h0102_0304);

        applyStimulus(1'b1, 4'hF, 32'h3800_0000, 32'hDEAD_BEEF);
        repeat (4) @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        releaseBus();
        #1;
        checkOutput("midRstAck", 64'(wbs_ack_o), 64'h0);
        checkOutput("midRstDat", 64'(wbs_dat_o), 64'h0);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        wbXfer(1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        checkOutput("rstKeep", 64'(rd), 64'h0102_0304);

        wbXfer(1'b1, 4'hF, 32'h3800_1004, 32'h5A5A_5A5A, rd, lat);
        wbXfer(1'b0, 4'hF, 32'h3800_0004, 32'h0, rd, lat);
        checkOutput("alias", 64'(rd), 64'h5A5A_5A5A);

        pulseReset();
        wbXfer(1'b1, 4'hF, 32'h3800_0020, 32'h0000_0001, rd, lat);
        wbXfer(1'b1, 4'hF, 32'h3800_0024, 32'h0000_0002, rd, lat);
        wbXfer(1'b1, 4'hF, 32'h3800_0028, 32'h0000_0003, rd, lat);
        wbXfer(1'b0, 4'hF, 32'h3800_0024, 32'h0, rd, lat);
        checkOutput("statsRd1", 64'(rd), 64'h0000_0002);
        wbXfer(1'b0, 4'hF, 32'h3800_0028, 32'h0, rd, lat);
        checkOutput("statsRd2", 64'(rd), 64'h0000_0003);
        abortReq(1'b0, 32'h3800_0020, 32'h0, 6, acks);
        checkOutput("statsAbort", 64'(acks), 64'd0);
        @(negedge wb_clk_i);
`ifdef STATS_EN
        expStats = {32'd3, 32'd2};
        checkOutput("statsModel", stats_o, {32'(wrCntM), 32'(rdCntM)});
`else
        expStats = 64'h0;
`endif
        checkOutput("stats", stats_o, expStats);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_exmem_ctrl.md
Name: wb_exmem_ctrl

Overview:
Wishbone slave in the user project that serves the mprjram window at 0x3800_0000. The window holds the program and data regions the management core executes from (matmul and similar kernels). It inserts a programmable number of wait states to model slow external memory, then performs a single-port, byte-writable BRAM access. It is the stage directly downstream of the management SoC bus and feeds instruction and data words back to the core, whose results reach mprj_io checkbits.

Parameters:
DELAY, 10, wait-state cycles before the BRAM access; legal range 1..255.
ADDR_W, 10, BRAM word-address width; depth is 2^ADDR_W 32-bit words.
BASE_HI, 8'h38, required value of wbs_adr_i[31:24] for a hit.

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  asynchronous, active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  1 = write
wbs_sel_i  in  4  byte enables
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  one-cycle acknowledge
wbs_dat_o  out  32  read data
stats_o  out  64  {wr_cnt[31:0], rd_cnt[31:0]}; tied to 0 unless STATS_EN is defined

Behaviour:
- Reset (async, wb_rst_i=1): state IDLE, cnt=0, wbs_ack_o=0, wbs_dat_o=0, captured request registers 0. BRAM contents are not reset.
- Hit condition: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==BASE_HI). Non-hits are ignored and never acked.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on a hit sampled at edge E0, capture we, sel, word address (wbs_adr_i[ADDR_W+1:2]), and dat_i; go to WAIT with cnt=0.
- Upper address bits between ADDR_W+2 and 23 are ignored, so addresses alias modulo the BRAM depth.
- WAIT: cnt increments each edge.
  - While cnt==DELAY-1, BRAM enable is driven combinationally from the captured request.
  - Write: bytes with sel=1 are written at that edge; bytes with sel=0 are unchanged.
  - Read: the word is latched into wbs_dat_o at that edge.
  - The same edge moves the FSM to ACK.
- ACK: wbs_ack_o=1 for exactly one cycle; next edge returns to IDLE with wbs_ack_o=0.
  - wbs_dat_o holds the last read word until the next read completes; it is unchanged by writes.
- Latency: ack is high during the cycle after edge E(DELAY). Minimum spacing between back-to-back requests is DELAY+2 cycles.
- Inputs changing during WAIT have no effect, because the captured copy is used.
- Abort: wbs_cyc_i=0 during WAIT returns the FSM to IDLE at the next edge. No BRAM access occurs, no ack is issued, and no write is performed.
- Reset mid-operation: immediate IDLE; a pending write is not performed.
- A hit sampled in ACK is not accepted; the FSM always passes through IDLE first.

Optional Feature:
STATS_EN
- Defined: two 32-bit counters.
  - rd_cnt and wr_cnt increment on each completed read or write ack; aborted requests are not counted.
  - Both counters wrap at 2^32 and reset to 0.
  - Both are driven on stats_o for routing to la_data_out.
- Not defined: no counters are synthesised and stats_o=64'h0.

Decomposition:
- Package exmem_pkg: state enum {IDLE, WAIT, ACK}, BASE_HI default, DELAY default, counter width constant.
- Sub-module bram_sp32 (natural split):
  - Single-port 2^ADDR_W x 32 array, synchronous read, per-byte write enables.
  - Instantiated once inside wb_exmem_ctrl.
  - Swappable for a hard macro.

Test Plan:
1. Write 0x1122_3344 to 0x3800_0010 with sel=4'hF, DELAY=10 -> ack in the 11th cycle after the request edge, width exactly 1. Read of 0x3800_0010 -> wbs_dat_o=0x1122_3344.
2. Partial write 0xAABB_CCDD to 0x3800_0010 with sel=4'b0101 after scenario 1 -> read returns 0x11BB_33DD.
3. Request to 0x3000_0000 or 0x3900_0000 -> no ack for 50 cycles, no BRAM change, FSM stays IDLE.
4. Write 0xDEAD_BEEF to 0x3800_0000, then drop cyc at cnt=5 -> no ack; a later read of 0x3800_0000 returns the prior value. Same result when wb_rst_i is pulsed mid-WAIT, which also forces ack=0 and dat_o=0 immediately.
5. Alias check with ADDR_W=10: write 0x5A5A_5A5A to 0x3800_1004 -> read of 0x3800_0004 returns 0x5A5A_5A5A.
6. STATS_EN defined: 3 writes, 2 reads, 1 aborted read -> stats_o = {32'd3, 32'd2}. Without STATS_EN -> stats_o=0.
